// File: rtl/sprite_drawer.sv
// sprite_drawer
//   Walks a SPRITE_W x SPRITE_H box anchored at a latched top-left coordinate
//   and emits one pixel write per cycle to the VGA adapter.
//     - Background mode copies background ROM pixels, erasing the character.
//     - Character mode copies character ROM pixels, skipping the colour key.
//   A single-cycle doneBG / doneChar pulse reports completion to the
//   movement FSM. The FSM then waits for the request line to fall before it
//   accepts a new request.
//
//   Both ROMs have one cycle of read latency. The scan counters drive the ROM
//   addresses combinationally. The screen position of each pixel is
//   registered alongside a valid bit, so position, ROM data and the plot
//   decision line up in the following cycle.
module sprite_drawer #(
  parameter int                  SPRITE_W    = 16,
  parameter int                  SPRITE_H    = 16,
  parameter int                  COLOUR_W    = 9,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = 9'h1C7,
  parameter int                  SCREEN_W    = 320,
  parameter int                  SCREEN_H    = 240,
  localparam int                 SPR_AW      = $clog2(SPRITE_W * SPRITE_H)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                drawBG,
  input  logic                drawChar,
  input  logic [8:0]          xCoordinate,
  input  logic [7:0]          yCoordinate,
  output logic [16:0]         bg_addr,
  input  logic [COLOUR_W-1:0] bg_data,
  output logic [SPR_AW-1:0]   spr_addr,
  input  logic [COLOUR_W-1:0] spr_data,
  output logic [8:0]          vga_x,
  output logic [7:0]          vga_y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                doneBG,
  output logic                doneChar
);

  // Counter widths; a one-pixel dimension still needs a one-bit counter.
  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(SPRITE_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(SPRITE_H - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SCAN    = 3'd1,
    S_FLUSH   = 3'd2,
    S_DONE    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  // Sequencer state and latched request context.
  state_t        state_r;
  logic [CW-1:0] c_r;
  logic [RW-1:0] r_r;
  logic [8:0]    x0_r;
  logic [7:0]    y0_r;
  logic          mode_char_r;   // 1: character box, 0: background box

  // Pixel pipeline: screen position of the pixel whose ROM data is arriving.
  logic [9:0]    col_r;
  logic [8:0]    row_r;
  logic          valid_r;

  // Registered completion pulses.
  logic          done_bg_r;
  logic          done_char_r;

  // Combinational helpers.
  logic [9:0]    scan_col_s;
  logic [8:0]    scan_row_s;
  logic [16:0]   row_wide_s;
  logic [16:0]   col_wide_s;
  logic          req_line_s;
  logic          on_screen_s;
  logic          keyed_s;

  // Screen position of the pixel currently being addressed. The widths are
  // wide enough that a box hanging off the right or bottom edge never wraps.
  assign scan_col_s = {1'b0, x0_r} + 10'(c_r);
  assign scan_row_s = {1'b0, y0_r} + 9'(r_r);
  assign row_wide_s = 17'(scan_row_s);
  assign col_wide_s = 17'(scan_col_s);

  // Background ROM is row-major with one screen line per row. A 320-pixel
  // pitch reduces to two shifts and an add. Clipped pixels may address past
  // the ROM; their data is discarded by the plot gate.
  if (SCREEN_W == 320) begin : g_bg_addr_320
    assign bg_addr = (row_wide_s << 8) + (row_wide_s << 6) + col_wide_s;
  end else begin : g_bg_addr_mul
    assign bg_addr = (row_wide_s * 17'(SCREEN_W)) + col_wide_s;
  end

  // Character ROM is row-major within the sprite.
  assign spr_addr = SPR_AW'((int'(r_r) * SPRITE_W) + int'(c_r));

  // The request line that started the current draw; RELEASE waits on it.
  assign req_line_s = mode_char_r ? drawChar : drawBG;

  // Plot gate: clip to the screen. Key only character pixels, because
  // background pixels must always overwrite the character.
  assign on_screen_s = (col_r < 10'(SCREEN_W)) && (row_r < 9'(SCREEN_H));
  assign keyed_s     = mode_char_r && (spr_data == TRANSPARENT);
  assign plot        = valid_r && on_screen_s && !keyed_s;
  assign colour      = mode_char_r ? spr_data : bg_data;

  assign vga_x    = col_r[8:0];
  assign vga_y    = row_r[7:0];
  assign doneBG   = done_bg_r;
  assign doneChar = done_char_r;

  // Draw sequencer: request capture, box scan, pipeline flush, done pulse,
  // and request-release handshake.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r     <= S_IDLE;
      c_r         <= '0;
      r_r         <= '0;
      x0_r        <= 9'd0;
      y0_r        <= 8'd0;
      mode_char_r <= 1'b0;
      col_r       <= 10'd0;
      row_r       <= 9'd0;
      valid_r     <= 1'b0;
      done_bg_r   <= 1'b0;
      done_char_r <= 1'b0;
    end else begin
      // Pulses and the pipeline valid bit are re-asserted only where needed.
      valid_r     <= 1'b0;
      done_bg_r   <= 1'b0;
      done_char_r <= 1'b0;

      case (state_r)
        S_IDLE: begin
          // Background has priority when both requests are present.
          if (drawBG) begin
            mode_char_r <= 1'b0;
            x0_r        <= xCoordinate;
            y0_r        <= yCoordinate;
            c_r         <= '0;
            r_r         <= '0;
            state_r     <= S_SCAN;
          end else if (drawChar) begin
            mode_char_r <= 1'b1;
            x0_r        <= xCoordinate;
            y0_r        <= yCoordinate;
            c_r         <= '0;
            r_r         <= '0;
            state_r     <= S_SCAN;
          end else begin
            state_r     <= S_IDLE;
          end
        end

        S_SCAN: begin
          // The address for (r,c) is on the ROM ports this cycle. Carry its
          // screen position into the pipeline for the plot next cycle.
          col_r   <= scan_col_s;
          row_r   <= scan_row_s;
          valid_r <= 1'b1;
          if (c_r == C_LAST) begin
            c_r <= '0;
            if (r_r == R_LAST) begin
              r_r     <= '0;
              state_r <= S_FLUSH;
            end else begin
              r_r     <= r_r + RW'(1);
              state_r <= S_SCAN;
            end
          end else begin
            c_r     <= c_r + CW'(1);
            state_r <= S_SCAN;
          end
        end

        S_FLUSH: begin
          // The last pixel is plotted this cycle; arm the matching done pulse.
          done_bg_r   <= !mode_char_r;
          done_char_r <= mode_char_r;
          state_r     <= S_DONE;
        end

        S_DONE: begin
          state_r <= S_RELEASE;
        end

        S_RELEASE: begin
          // A request still held high must not start a second draw.
          if (!req_line_s) begin
            state_r <= S_IDLE;
          end else begin
            state_r <= S_RELEASE;
          end
        end

        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_drawer.sv
// tb_sprite_drawer
//   Randomized and directed stimulus for sprite_drawer. A behavioural model
//   derives, for every cycle of a draw, the pixel write or done pulse that
//   should appear.
module tb_sprite_drawer;

  localparam int SW    = 16;
  localparam int SH    = 16;
  localparam int N     = SW * SH;
  localparam int SCR_W = 320;
  localparam int SCR_H = 240;
  localparam logic [8:0] KEY = 9'h1C7;

  logic        clock;
  logic        resetn;
  logic        drawBG;
  logic        drawChar;
  logic [8:0]  xCoordinate;
  logic [7:0]  yCoordinate;
  logic [16:0] bg_addr;
  logic [8:0]  bg_data;
  logic [7:0]  spr_addr;
  logic [8:0]  spr_data;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [8:0]  colour;
  logic        plot;
  logic        doneBG;
  logic        doneChar;

  logic [8:0]  spr_mem [0:N-1];

  int n_compared;
  int n_mismatched;

  sprite_drawer dut (
    .clock       (clock),
    .resetn      (resetn),
    .drawBG      (drawBG),
    .drawChar    (drawChar),
    .xCoordinate (xCoordinate),
    .yCoordinate (yCoordinate),
    .bg_addr     (bg_addr),
    .bg_data     (bg_data),
    .spr_addr    (spr_addr),
    .spr_data    (spr_data),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .colour      (colour),
    .plot        (plot),
    .doneBG      (doneBG),
    .doneChar    (doneChar)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Background ROM contents are a fixed function of the address.
  function automatic logic [8:0] bg_fn(input logic [16:0] a);
    return 9'((a * 17'd37) ^ (a >> 5));
  endfunction

  // ROM models with one cycle of read latency.
  always @(posedge clock) begin
    bg_data  <= bg_fn(bg_addr);
    spr_data <= spr_mem[spr_addr];
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {plot, doneBG, doneChar, x, y, colour} for cycle k of a draw
  // requested at cycle 0. Pixel p = r*SW + c is plotted at cycle p+2.
  function automatic logic [28:0] expect_at(input int k, input int x, input int y, input bit mode);
    int p;
    int col;
    int row;
    logic [8:0] pix;
    if (k >= 2 && k <= N + 1) begin
      p   = k - 2;
      col = x + (p % SW);
      row = y + (p / SW);
      if (col >= SCR_W || row >= SCR_H) return 29'd0;
      if (mode && spr_mem[p] == KEY) return 29'd0;
      pix = mode ? spr_mem[p] : bg_fn(17'(row * SCR_W + col));
      return {1'b1, 1'b0, 1'b0, 9'(col), 8'(row), pix};
    end
    if (k == N + 2) return {1'b0, !mode, mode, 26'd0};
    return 29'd0;
  endfunction

  // One draw from request to return to idle.
  //   hold:     cycle at which the request line(s) are dropped
  //   other_at: cycle at which the other request line also rises (-1: never)
  //   reset_at: cycle at which resetn is pulled low (-1: never)
  task automatic run_draw(input int x, input int y, input bit mode, input int hold,
                          input int other_at, input int reset_at,
                          output int plots, output int exp_plots);
    int last;
    int p;
    logic [28:0] obs;
    logic [28:0] expv;
    logic [16:0] exp_addr;
    plots     = 0;
    exp_plots = 0;
    last      = ((hold > N + 2) ? hold : N + 2) + 4;
    @(negedge clock);
    xCoordinate = 9'(x);
    yCoordinate = 8'(y);
    if (mode) drawChar = 1'b1; else drawBG = 1'b1;
    if (other_at == 0) begin
      if (mode) drawBG = 1'b1; else drawChar = 1'b1;
    end
    for (int k = 1; k <= last; k++) begin
      @(negedge clock);
      if (k <= N && (reset_at < 0 || k <= reset_at)) begin
        p = k - 1;
        exp_addr = 17'((y + p / SW) * SCR_W + (x + p % SW));
        check_value($sformatf("bg_addr@%0d", k), 32'(bg_addr), 32'(exp_addr));
        check_value($sformatf("spr_addr@%0d", k), 32'(spr_addr), 32'(p));
      end
      obs  = {plot, doneBG, doneChar, plot ? {vga_x, vga_y, colour} : 26'd0};
      expv = (reset_at >= 0 && k > reset_at) ? 29'd0 : expect_at(k, x, y, mode);
      if (expv[28]) exp_plots++;
      if (plot === 1'b1) plots++;
      check_value($sformatf("pixel@%0d", k), 32'(obs), 32'(expv));
      if (reset_at >= 0 && k == reset_at + 1) begin
        check_value("rst_vga_x", 32'(vga_x), 32'd0);
        check_value("rst_vga_y", 32'(vga_y), 32'd0);
      end
      // Drive for the next edge.
      if (k == other_at) begin
        if (mode) drawBG = 1'b1; else drawChar = 1'b1;
      end
      if (k == hold) begin
        drawBG   = 1'b0;
        drawChar = 1'b0;
      end
      if (k == reset_at) begin
        resetn   = 1'b0;
        drawBG   = 1'b0;
        drawChar = 1'b0;
      end
      if (reset_at >= 0 && k == reset_at + 3) resetn = 1'b1;
      // Coordinates wander during the draw; the DUT must not re-sample them.
      xCoordinate = 9'($urandom);
      yCoordinate = 8'($urandom);
    end
  endtask

  int plots;
  int exp_plots;
  int x;
  int y;
  int hold;
  int other_at;
  bit mode;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    resetn       = 1'b0;
    drawBG       = 1'b0;
    drawChar     = 1'b0;
    xCoordinate  = 9'd0;
    yCoordinate  = 8'd0;
    for (int i = 0; i < N; i++) spr_mem[i] = 9'($urandom);

    // Reset held for three cycles.
    repeat (3) @(negedge clock);
    check_value("reset_plot", 32'(plot), 32'd0);
    check_value("reset_doneBG", 32'(doneBG), 32'd0);
    check_value("reset_doneChar", 32'(doneChar), 32'd0);
    check_value("reset_vga_x", 32'(vga_x), 32'd0);
    check_value("reset_vga_y", 32'(vga_y), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Background box fully on screen.
    run_draw(95, 221, 1'b0, N + 3, -1, -1, plots, exp_plots);
    check_value("bg_plot_count", 32'(plots), 32'd256);

    // Character box with only word 0 keyed.
    for (int i = 0; i < N; i++) spr_mem[i] = 9'h038;
    spr_mem[0] = KEY;
    run_draw(126, 68, 1'b1, N + 3, -1, -1, plots, exp_plots);
    check_value("char_plot_count", 32'(plots), 32'd255);

    // Background box clipped at the bottom-right corner.
    run_draw(310, 230, 1'b0, N + 3, -1, -1, plots, exp_plots);
    check_value("clip_plot_count", 32'(plots), 32'd100);

    // Character request held for 400 cycles: a single pulse, no retrigger.
    for (int i = 0; i < N; i++) spr_mem[i] = ($urandom_range(0, 3) == 0) ? KEY : 9'($urandom);
    run_draw(40, 20, 1'b1, 400, -1, -1, plots, exp_plots);
    check_value("held_plot_count", 32'(plots), 32'(exp_plots));

    // Reset at cycle 100 of a background draw, then a fresh full draw.
    run_draw(60, 50, 1'b0, N + 3, -1, 100, plots, exp_plots);
    check_value("abort_plot_count", 32'(plots), 32'(exp_plots));
    run_draw(60, 50, 1'b0, N + 3, -1, -1, plots, exp_plots);
    check_value("after_reset_plot_count", 32'(plots), 32'd256);

    // Randomized draws: any position, either mode, early request drop,
    // and the other request line rising mid-draw or arriving with it.
    for (int t = 0; t < 18; t++) begin
      mode = 1'($urandom_range(0, 1));
      x    = $urandom_range(0, 511);
      y    = $urandom_range(0, 255);
      for (int i = 0; i < N; i++) spr_mem[i] = ($urandom_range(0, 3) == 0) ? KEY : 9'($urandom);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 250) : N + 3;
      if ($urandom_range(0, 2) == 0) other_at = -1;
      else if (mode == 1'b0)         other_at = $urandom_range(0, 200);
      else                           other_at = $urandom_range(1, 200);
      if (other_at >= hold) other_at = -1;
      run_draw(x, y, mode, hold, other_at, -1, plots, exp_plots);
      check_value($sformatf("rand%0d_plot_count", t), 32'(plots), 32'(exp_plots));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
